// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: datapath width, base opcodes, immediate
// format classification and operand-usage helpers. Reused by the decode,
// execute and control blocks.
package riscv_pkg;

  localparam int XLEN = 64;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } immFmt_t;

  function automatic immFmt_t immFmtOf(input logic [6:0] opcode);
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR: return IMM_I;
      OPC_STORE:                                     return IMM_S;
      OPC_BRANCH:                                    return IMM_B;
      OPC_LUI, OPC_AUIPC:                            return IMM_U;
      OPC_JAL:                                       return IMM_J;
      default:                                       return IMM_NONE;
    endcase
  endfunction

  // rs1 field is a real source for everything except the U/J formats.
  function automatic logic usesRs1(input logic [6:0] opcode);
    return !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
  endfunction

  function automatic logic usesRs2(input logic [6:0] opcode);
    return (opcode == OPC_OP) || (opcode == OPC_OP_32) ||
           (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: purely combinational, sign-extends the immediate of
// the instruction's format to XLEN bits; unknown opcodes produce zero.
// Ports: instr (32-bit instruction word), imm (signed XLEN immediate).
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic        [31:0]     instr,
  output logic signed [XLEN-1:0] imm
);

  logic sgn;
  assign sgn = instr[31];

  always_comb begin
    imm = '0;
    case (immFmtOf(instr[6:0]))
      IMM_I: imm = {{(XLEN-12){sgn}}, instr[31:20]};
      IMM_S: imm = {{(XLEN-12){sgn}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{(XLEN-13){sgn}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      IMM_U: imm = {{(XLEN-32){sgn}}, instr[31:12], 12'b0};
      IMM_J: imm = {{(XLEN-21){sgn}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage with ID/EX pipeline register.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   if_valid/instr/pc     IF/ID instruction
//   stall, flush          ID/EX hold and kill controls
//   rs1_addr, rs2_addr    register-file read addresses (combinational)
//   rs1_data, rs2_data    register-file read data
//   wb_we/rd/data         write-back bus, bypassed into the operands
//   ex_*                  ID/EX register contents
//   hazard_stall          load-use hold request to IF (combinational)
//   bubble_cnt            saturating count of load-use bubbles
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            stall,
  input  logic            flush,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_funct7,
  output logic            ex_mem_read,
  output logic            hazard_stall,
  output logic [31:0]     bubble_cnt
);

  function automatic logic [31:0] satInc(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

  // x0 always reads zero; otherwise a matching write-back wins over the
  // register file so the instruction sees the value retiring this cycle.
  function automatic logic signed [XLEN-1:0] operand(
    input logic [4:0]      addr,
    input logic [XLEN-1:0] rfData,
    input logic            we,
    input logic [4:0]      rd,
    input logic [XLEN-1:0] wbData
  );
    if (addr == 5'd0)                        return '0;
    else if (we && rd != 5'd0 && rd == addr) return wbData;
    else                                     return rfData;
  endfunction

  // ---- stage p0: decode of the IF/ID instruction ----
  logic        [6:0]      opcode_p0;
  logic signed [XLEN-1:0] rs1Val_p0;
  logic signed [XLEN-1:0] rs2Val_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic                   rs1Hit;
  logic                   rs2Hit;

  assign opcode_p0 = if_instr[6:0];
  assign rs1_addr  = if_instr[19:15];
  assign rs2_addr  = if_instr[24:20];
  assign rs1Val_p0 = operand(rs1_addr, rs1_data, wb_we, wb_rd, wb_data);
  assign rs2Val_p0 = operand(rs2_addr, rs2_data, wb_we, wb_rd, wb_data);

  imm_gen #(.XLEN(XLEN)) uImmGen (
    .instr (if_instr),
    .imm   (imm_p0)
  );

  // ---- stage p1: ID/EX register ----
  logic                   vld_p1;
  logic                   memRead_p1;
  logic        [XLEN-1:0] pc_p1;
  logic signed [XLEN-1:0] rs1Val_p1;
  logic signed [XLEN-1:0] rs2Val_p1;
  logic signed [XLEN-1:0] imm_p1;
  logic        [4:0]      rd_p1;
  logic        [6:0]      opcode_p1;
  logic        [2:0]      funct3_p1;
  logic        [6:0]      funct7_p1;
  logic        [31:0]     bubbleCnt;

  // A load in EX whose destination feeds this instruction cannot be
  // bypassed yet; stall and flush already freeze or kill the pipe, so the
  // request is masked then.
  assign rs1Hit = usesRs1(opcode_p0) && (rd_p1 == rs1_addr);
  assign rs2Hit = usesRs2(opcode_p0) && (rd_p1 == rs2_addr);
  assign hazard_stall = if_valid && vld_p1 && memRead_p1 && (rd_p1 != 5'd0) &&
                        (rs1Hit || rs2Hit) && !stall && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      memRead_p1 <= 1'b0;
      pc_p1      <= '0;
      rs1Val_p1  <= '0;
      rs2Val_p1  <= '0;
      imm_p1     <= '0;
      rd_p1      <= '0;
      opcode_p1  <= '0;
      funct3_p1  <= '0;
      funct7_p1  <= '0;
      bubbleCnt  <= '0;
    end else if (flush) begin
      vld_p1     <= 1'b0;
      memRead_p1 <= 1'b0;
    end else if (stall) begin
      vld_p1     <= vld_p1;
    end else if (hazard_stall) begin
      vld_p1     <= 1'b0;
      memRead_p1 <= 1'b0;
      bubbleCnt  <= satInc(bubbleCnt);
    end else begin
      vld_p1     <= if_valid;
      memRead_p1 <= (opcode_p0 == OPC_LOAD);
      pc_p1      <= if_pc;
      rs1Val_p1  <= rs1Val_p0;
      rs2Val_p1  <= rs2Val_p0;
      imm_p1     <= imm_p0;
      rd_p1      <= if_instr[11:7];
      opcode_p1  <= opcode_p0;
      funct3_p1  <= if_instr[14:12];
      funct7_p1  <= if_instr[31:25];
    end
  end

  assign ex_valid    = vld_p1;
  assign ex_mem_read = memRead_p1;
  assign ex_pc       = pc_p1;
  assign ex_rs1_val  = rs1Val_p1;
  assign ex_rs2_val  = rs2Val_p1;
  assign ex_imm      = imm_p1;
  assign ex_rd       = rd_p1;
  assign ex_opcode   = opcode_p1;
  assign ex_funct3   = funct3_p1;
  assign ex_funct7   = funct7_p1;
  assign bubble_cnt  = bubbleCnt;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  localparam logic [6:0] LOAD = 7'b0000011, OPIMM = 7'b0010011, OPIMM32 = 7'b0011011,
                         JALR = 7'b1100111, STORE = 7'b0100011, BRANCH = 7'b1100011,
                         LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                         OP = 7'b0110011, OP32 = 7'b0111011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        stall, flush;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [63:0] rs1_data, rs2_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        ex_valid;
  logic [63:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic        ex_mem_read;
  logic        hazard_stall;
  logic [31:0] bubble_cnt;

  int errors = 0;
  int checks = 0;

  // reference ID/EX contents
  logic        mValid, mMem;
  logic [63:0] mPc, mRs1, mRs2, mImm;
  logic [4:0]  mRd;
  logic [6:0]  mOpc, mF7;
  logic [2:0]  mF3;
  logic [31:0] mBub;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .stall(stall), .flush(flush), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val),
    .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_mem_read(ex_mem_read),
    .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
  );

  task automatic checkEq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Immediate value rebuilt arithmetically from the bit-scattered fields.
  function automatic logic [63:0] refImm(input logic [31:0] ins);
    longint v;
    case (ins[6:0])
      LOAD, OPIMM, OPIMM32, JALR: begin
        v = longint'(ins[31:20]);
        if (v >= 2048) v -= 4096;
      end
      STORE: begin
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (v >= 2048) v -= 4096;
      end
      BRANCH: begin
        v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
            longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      LUI, AUIPC: begin
        v = longint'(ins[31:12]) * 4096;
        if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000;
      end
      JAL: begin
        v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
            longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic logic [63:0] refOperand(input logic [4:0] a, input logic [63:0] rf);
    if (a == 0) return 64'd0;
    if (wb_we && wb_rd == a) return wb_data;
    return rf;
  endfunction

  function automatic logic refHazard();
    logic [6:0] op;
    logic r1u, r2u;
    op  = if_instr[6:0];
    r1u = !(op == LUI || op == AUIPC || op == JAL);
    r2u = (op == OP || op == OP32 || op == STORE || op == BRANCH);
    if (stall || flush || !if_valid || !mValid || !mMem || mRd == 0) return 1'b0;
    return (r1u && mRd == if_instr[19:15]) || (r2u && mRd == if_instr[24:20]);
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic s, input logic f,
                       input logic we, input logic [4:0] wrd, input logic [63:0] wd,
                       input logic [63:0] d1, input logic [63:0] d2);
    if_valid = v; if_instr = ins; if_pc = {$urandom, $urandom};
    stall = s; flush = f; wb_we = we; wb_rd = wrd; wb_data = wd;
    rs1_data = d1; rs2_data = d2;
  endtask

  // One clock: check combinational outputs, advance the model, check ID/EX.
  task automatic cycle();
    logic haz;
    #1;
    haz = refHazard();
    checkEq("hazard", hazard_stall, haz);
    checkEq("rs1Addr", rs1_addr, if_instr[19:15]);
    checkEq("rs2Addr", rs2_addr, if_instr[24:20]);
    @(posedge clk);
    if (!rst_n) begin
      mValid = 0; mMem = 0; mPc = 0; mRs1 = 0; mRs2 = 0; mImm = 0;
      mRd = 0; mOpc = 0; mF3 = 0; mF7 = 0; mBub = 0;
    end else if (flush) begin
      mValid = 0; mMem = 0;
    end else if (stall) begin
      mValid = mValid;
    end else if (haz) begin
      mValid = 0; mMem = 0;
      if (mBub != 32'hFFFF_FFFF) mBub = mBub + 1;
    end else begin
      mValid = if_valid; mMem = (if_instr[6:0] == LOAD); mPc = if_pc;
      mRs1 = refOperand(if_instr[19:15], rs1_data);
      mRs2 = refOperand(if_instr[24:20], rs2_data);
      mImm = refImm(if_instr); mRd = if_instr[11:7]; mOpc = if_instr[6:0];
      mF3 = if_instr[14:12]; mF7 = if_instr[31:25];
    end
    @(negedge clk);
    checkEq("exValid", ex_valid, mValid);
    checkEq("exMemRead", ex_mem_read, mMem);
    checkEq("bubbleCnt", bubble_cnt, mBub);
    if (mValid) begin
      checkEq("exPc", ex_pc, mPc);
      checkEq("exRs1", ex_rs1_val, mRs1);
      checkEq("exRs2", ex_rs2_val, mRs2);
      checkEq("exImm", ex_imm, mImm);
      checkEq("exRd", ex_rd, mRd);
      checkEq("exOpc", ex_opcode, mOpc);
      checkEq("exF3", ex_funct3, mF3);
      checkEq("exF7", ex_funct7, mF7);
    end
  endtask

  function automatic logic [31:0] randInstr();
    logic [6:0] opcs [11] = '{LOAD, OPIMM, OPIMM32, JALR, STORE, BRANCH, LUI, AUIPC, JAL, OP, OP32};
    logic [31:0] ins;
    int k;
    ins = $urandom;
    k = $urandom_range(0, 11);
    ins[6:0]   = (k == 11) ? 7'($urandom) : opcs[k];
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    ins[11:7]  = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  initial begin
    logic [31:0] addX1, addiX2, ldX3, addX7, beqM8, luiX1;
    addX1  = {7'd0, 5'd6, 5'd5, 3'd0, 5'd1, OP};
    addiX2 = {12'hFFF, 5'd0, 3'd0, 5'd2, OPIMM};
    ldX3   = {12'd0, 5'd4, 3'b011, 5'd3, LOAD};
    addX7  = {7'd0, 5'd3, 5'd3, 3'd0, 5'd7, OP};
    beqM8  = {1'b1, 6'b111111, 5'd0, 5'd0, 3'd0, 4'b1100, 1'b1, BRANCH};
    luiX1  = {20'h80000, 5'd1, LUI};

    mValid = 0; mMem = 0; mPc = 0; mRs1 = 0; mRs2 = 0; mImm = 0;
    mRd = 0; mOpc = 0; mF3 = 0; mF7 = 0; mBub = 0;
    rst_n = 1'b0;
    drive(1, addX1, 0, 0, 0, 0, 0, 64'h1, 64'h2);
    @(negedge clk);
    cycle(); cycle();
    checkEq("rstValid", ex_valid, 0);
    checkEq("rstPc", ex_pc, 0);
    checkEq("rstImm", ex_imm, 0);
    checkEq("rstBub", bubble_cnt, 0);
    rst_n = 1'b1;

    // load-use: ld x3 then add x7,x3,x3
    drive(1, ldX3, 0, 0, 0, 0, 0, 64'h40, 64'h0);
    cycle();
    drive(1, addX7, 0, 0, 0, 0, 0, 64'h11, 64'h11);
    #1 checkEq("luHazard", hazard_stall, 1);
    cycle();
    checkEq("luBubble", ex_valid, 0);
    checkEq("luCnt", bubble_cnt, 1);
    cycle();
    checkEq("luResume", ex_valid, 1);
    checkEq("luCntHeld", bubble_cnt, 1);

    // write-back bypass on rs1
    drive(1, addX1, 0, 0, 1, 5'd5, 64'hDEAD, 64'h0, 64'h66);
    cycle();
    checkEq("bypassRs1", ex_rs1_val, 64'hDEAD);

    // x0 ignores a write-back targeting x0
    drive(1, addiX2, 0, 0, 1, 5'd0, 64'h7, 64'h1234, 64'h0);
    cycle();
    checkEq("x0Rs1", ex_rs1_val, 0);
    checkEq("x0Imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFF);

    drive(1, beqM8, 0, 0, 0, 0, 0, 64'h5, 64'h5);
    cycle();
    checkEq("beqImm", ex_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    drive(1, luiX1, 0, 0, 0, 0, 0, 64'h5, 64'h5);
    cycle();
    checkEq("luiImm", ex_imm, 64'hFFFF_FFFF_8000_0000);

    // flush beats stall
    drive(1, addX1, 1, 1, 0, 0, 0, 64'h5, 64'h5);
    cycle();
    checkEq("flushOverStall", ex_valid, 0);

    // reset during stall
    drive(1, ldX3, 0, 0, 0, 0, 0, 64'h9, 64'h9);
    cycle();
    drive(1, addX7, 1, 0, 0, 0, 0, 64'h9, 64'h9);
    cycle();
    checkEq("stallHold", ex_valid, 1);
    rst_n = 1'b0;
    cycle();
    checkEq("rstStValid", ex_valid, 0);
    checkEq("rstStMem", ex_mem_read, 0);
    checkEq("rstStRs1", ex_rs1_val, 0);
    checkEq("rstStRd", ex_rd, 0);
    checkEq("rstStOpc", ex_opcode, 0);
    checkEq("rstStBub", bubble_cnt, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      drive($urandom_range(0, 7) != 0, randInstr(), $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7)), {$urandom, $urandom},
            {$urandom, $urandom}, {$urandom, $urandom});
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports if_valid (input, 1), if_instr (input, 32) and if_pc (input, XLEN), carrying the IF/ID instruction, its PC and a valid flag.
REQ-005 SHALL have ports stall (input, 1), which holds the ID/EX register, and flush (input, 1), which kills the instruction entering EX.
REQ-006 SHALL have ports rs1_addr and rs2_addr (output, 5 each), driving the register-file read addresses.
REQ-007 SHALL have ports rs1_data and rs2_data (input, XLEN each), carrying the register-file read data.
REQ-008 SHALL have ports wb_we (input, 1), wb_rd (input, 5) and wb_data (input, XLEN), carrying the write-back bus also driven into the register file.
REQ-009 SHALL have ports ex_valid (output, 1), ex_pc (output, XLEN), ex_rs1_val, ex_rs2_val and ex_imm (output, XLEN each), ex_rd (output, 5), ex_opcode (output, 7), ex_funct3 (output, 3), ex_funct7 (output, 7) and ex_mem_read (output, 1), forming the ID/EX register.
REQ-010 SHALL have port hazard_stall  output  1  load-use hold request to IF, combinational.
REQ-011 SHALL have port bubble_cnt  output  32  count of inserted load-use bubbles.

Function
REQ-012 SHALL drive rs1_addr = if_instr[19:15] and rs2_addr = if_instr[24:20] combinationally.
REQ-013 SHALL bypass: an operand equals wb_data when wb_we=1, wb_rd!=0 and wb_rd matches that operand's address; otherwise it equals rs*_data.
REQ-014 SHALL force an operand to 0 when its address is 0, regardless of bypass.
REQ-015 SHALL generate sign-extended XLEN immediates by opcode: I (LOAD 0000011, OP-IMM 0010011, OP-IMM-32 0011011, JALR 1100111), S (0100011), B (1100011), U (LUI 0110111, AUIPC 0010111) and J (1101111); all other opcodes give 0.
REQ-016 SHALL treat rs1 as used for all opcodes except LUI, AUIPC and JAL.
REQ-017 SHALL treat rs2 as used only for OP (0110011), OP-32 (0111011), STORE and BRANCH.
REQ-018 SHALL assert hazard_stall when all of the following hold: if_valid=1, ex_valid=1, ex_mem_read=1, ex_rd!=0, and ex_rd equals a used rs1 or rs2.
REQ-019 SHALL set ex_mem_read = 1 only for the LOAD opcode.
REQ-020 SHALL apply ID/EX register update priority per posedge as: reset > flush > stall > hazard_stall > load.
REQ-021 SHALL, on flush, clear ex_valid and ex_mem_read; other fields are don't-care.
REQ-022 SHALL, on stall without flush, hold all ID/EX outputs unchanged.
REQ-023 SHALL, on hazard_stall without stall or flush, clear ex_valid and ex_mem_read (bubble) and increment bubble_cnt.
REQ-024 SHALL, on load, capture ex_valid = if_valid together with the decoded fields, bypassed operands and immediate, giving one-cycle latency.
REQ-025 SHALL saturate bubble_cnt at 32'hFFFF_FFFF.
REQ-026 SHALL suppress hazard_stall assertion when stall or flush is also high in the same cycle, with no bubble counted.

Reset
REQ-027 SHALL, while rst_n=0 at posedge, set ex_valid=0, ex_mem_read=0, bubble_cnt=0 and every other ID/EX output to 0.
REQ-028 SHALL let reset override stall and flush, and discard any in-flight instruction.

Structure
REQ-029 SHALL place opcode constants and XLEN in a shared package, riscv_pkg, for reuse by the execute and control blocks.
REQ-030 SHALL implement immediate generation as one combinational sub-module, imm_gen.

Verification
REQ-031 SHALL verify the bypass: with wb_we=1, wb_rd=5, wb_data=64'hDEAD, rs1_data=0 and instr add x1,x5,x6, the next cycle gives ex_rs1_val=64'hDEAD.
REQ-032 SHALL verify x0: with instr addi x2,x0,-1 and wb_we=1, wb_rd=0, wb_data=7, the outcome is ex_rs1_val=0 and ex_imm=64'hFFFF_FFFF_FFFF_FFFF.
REQ-033 SHALL verify the load-use hazard: ld x3,0(x4) followed by add x7,x3,x3 gives one cycle of hazard_stall=1, then ex_valid=0 for one cycle, then bubble_cnt=1.
REQ-034 SHALL verify flush-over-stall: with stall=1, flush=1 and ex_valid previously 1, the next cycle gives ex_valid=0.
REQ-035 SHALL verify immediates: beq with offset -8 gives ex_imm=64'hFFFF_FFFF_FFFF_FFF8, and lui x1,0x80000 gives ex_imm=64'hFFFF_FFFF_8000_0000.
REQ-036 SHALL verify reset mid-stall: rst_n=0 while stall=1 gives all outputs 0 on the next cycle.
